// File: rtl/idli_sqi_ctrl_m.sv
// SQI (quad-SPI) SRAM controller: one 16-bit read or write per host request,
// with GAP_SCKS chip-deselected SCK pulses after every command and after reset.
//
// state | meaning
// IDLE  | CS high, SCK low, ready for a host request
// INSTR | two instruction nibbles (0x02 write / 0x03 read)
// ADDR  | four address nibbles, MSB first
// DUMMY | two released turnaround nibbles (read only)
// DATA  | four data nibbles, driven on write, sampled on read
// GAP   | CS high with GAP_SCKS SCK pulses to resync the memory
module idli_sqi_ctrl_m #(
   parameter int unsigned GAP_SCKS = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_vld,
   output logic        o_req_rdy,
   input  logic        i_req_wr,
   input  logic [15:0] i_req_addr,
   input  logic [15:0] i_req_wdata,
   output logic        o_rsp_vld,
   output logic [15:0] o_rsp_rdata,
   output logic        o_sqi_sck,
   output logic        o_sqi_cs,
   output logic [3:0]  o_sqi_sio,
   output logic        o_sqi_sio_en,
   input  logic [3:0]  i_sqi_sio
);

   localparam int GW = (GAP_SCKS > 1) ? $clog2(GAP_SCKS) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_SCKS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INSTR, S_ADDR, S_DUMMY, S_DATA, S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          wr_q, wr_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [11:0]   shift_q, shift_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          rsp_vld_q, rsp_vld_d;

   // Reset lands in GAP so a memory abandoned mid-command is resynchronised.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_GAP;
         cnt_q     <= '0;
         phase_q   <= 1'b0;
         gap_q     <= GAP_LOAD;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         shift_q   <= '0;
         rdata_q   <= '0;
         rsp_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         gap_q     <= gap_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         shift_q   <= shift_d;
         rdata_q   <= rdata_d;
         rsp_vld_q <= rsp_vld_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      gap_d     = gap_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      shift_d   = shift_q;
      rdata_d   = rdata_q;
      rsp_vld_d = 1'b0;
      if (state_q == S_IDLE) begin
         phase_d = 1'b0;
         if (i_req_vld) begin
            wr_d    = i_req_wr;
            addr_d  = i_req_addr;
            wdata_d = i_req_wdata;
            cnt_d   = '0;
            state_d = S_INSTR;
         end
      end else begin
         phase_d = ~phase_q;
         // Every state advances only at the end of phase 1 (SCK falling).
         if (phase_q) begin
            cnt_d = cnt_q + 3'd1;
            case (state_q)
               S_INSTR: if (cnt_q == 3'd1) begin
                  state_d = S_ADDR;
                  cnt_d   = '0;
               end
               S_ADDR: if (cnt_q == 3'd3) begin
                  state_d = wr_q ? S_DATA : S_DUMMY;
                  cnt_d   = '0;
               end
               S_DUMMY: if (cnt_q == 3'd1) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
               S_DATA: begin
                  shift_d = {shift_q[7:0], i_sqi_sio};
                  if (cnt_q == 3'd3) begin
                     state_d = S_GAP;
                     cnt_d   = '0;
                     gap_d   = GAP_LOAD;
                     if (!wr_q) begin
                        // Wire order is addr-byte then addr+1-byte; word is {addr+1, addr}.
                        rdata_d   = {shift_q[3:0], i_sqi_sio, shift_q[11:4]};
                        rsp_vld_d = 1'b1;
                     end
                  end
               end
               S_GAP: begin
                  cnt_d = '0;
                  if (gap_q == '0) state_d = S_IDLE;
                  else             gap_d   = gap_q - 1'b1;
               end
               default: state_d = S_GAP;
            endcase
         end
      end
   end

   always_comb begin
      o_req_rdy    = (state_q == S_IDLE);
      o_sqi_cs     = 1'b1;
      o_sqi_sck    = 1'b0;
      o_sqi_sio_en = 1'b0;
      o_sqi_sio    = 4'h0;
      case (state_q)
         S_INSTR: begin
            o_sqi_cs     = 1'b0;
            o_sqi_sck    = phase_q;
            o_sqi_sio_en = 1'b1;
            o_sqi_sio    = cnt_q[0] ? (wr_q ? 4'h2 : 4'h3) : 4'h0;
         end
         S_ADDR: begin
            o_sqi_cs     = 1'b0;
            o_sqi_sck    = phase_q;
            o_sqi_sio_en = 1'b1;
            case (cnt_q[1:0])
               2'd0:    o_sqi_sio = addr_q[15:12];
               2'd1:    o_sqi_sio = addr_q[11:8];
               2'd2:    o_sqi_sio = addr_q[7:4];
               default: o_sqi_sio = addr_q[3:0];
            endcase
         end
         S_DUMMY: begin
            o_sqi_cs  = 1'b0;
            o_sqi_sck = phase_q;
         end
         S_DATA: begin
            o_sqi_cs     = 1'b0;
            o_sqi_sck    = phase_q;
            o_sqi_sio_en = wr_q;
            if (wr_q) begin
               case (cnt_q[1:0])
                  2'd0:    o_sqi_sio = wdata_q[7:4];
                  2'd1:    o_sqi_sio = wdata_q[3:0];
                  2'd2:    o_sqi_sio = wdata_q[15:12];
                  default: o_sqi_sio = wdata_q[11:8];
               endcase
            end
         end
         S_GAP:   o_sqi_sck = phase_q;
         default: ;
      endcase
   end

   assign o_rsp_vld   = rsp_vld_q;
   assign o_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: directed requests against an SQI SRAM model,
// with a scoreboard of expected nibbles, CS-low lengths and read responses.
module tb_idli_sqi_ctrl_m;

   localparam int GAP = 2;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req_vld;
   logic        o_req_rdy;
   logic        i_req_wr;
   logic [15:0] i_req_addr;
   logic [15:0] i_req_wdata;
   logic        o_rsp_vld;
   logic [15:0] o_rsp_rdata;
   logic        o_sqi_sck;
   logic        o_sqi_cs;
   logic [3:0]  o_sqi_sio;
   logic        o_sqi_sio_en;
   logic [3:0]  i_sqi_sio;

   idli_sqi_ctrl_m #(.GAP_SCKS(GAP)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_req_vld    (i_req_vld),
      .o_req_rdy    (o_req_rdy),
      .i_req_wr     (i_req_wr),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .o_rsp_vld    (o_rsp_vld),
      .o_rsp_rdata  (o_rsp_rdata),
      .o_sqi_sck    (o_sqi_sck),
      .o_sqi_cs     (o_sqi_cs),
      .o_sqi_sio    (o_sqi_sio),
      .o_sqi_sio_en (o_sqi_sio_en),
      .i_sqi_sio    (i_sqi_sio)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   logic [3:0]  exp_nib[$];
   logic [15:0] exp_rsp[$];
   int          exp_cs[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- SQI SRAM model ----------------
   logic [7:0] mem [int];
   int         mc = 0;
   logic [3:0] mnib [0:11];
   logic       mem_drv = 1'b0;
   logic [3:0] mem_sio = 4'h0;
   logic [15:0] ma_w, ma_r;
   logic [7:0]  mb;
   int          gap_pulses = 0;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   function automatic logic [7:0] mrd(input logic [15:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : pat(a);
   endfunction

   assign i_sqi_sio = mem_sio;

   always @(negedge o_sqi_cs) begin
      chk("gap_pulses", gap_pulses, GAP);
      mc = 0;
      mem_drv = 1'b0;
   end

   always @(posedge o_sqi_cs) begin
      if (mc == 10 && {mnib[0], mnib[1]} == 8'h02) begin
         ma_w = {mnib[2], mnib[3], mnib[4], mnib[5]};
         mem[int'(ma_w)] = {mnib[6], mnib[7]};
         mem[int'(16'(ma_w + 16'd1))] = {mnib[8], mnib[9]};
      end
      mc = 0;
      mem_drv = 1'b0;
      gap_pulses = 0;
   end

   always @(posedge o_sqi_sck) begin
      logic exp_en;
      if (o_sqi_cs) gap_pulses++;
      else begin
         exp_en = (mc < 6) || (mc < 10 && {mnib[0], mnib[1]} == 8'h02);
         chk("sio_en", 32'(o_sqi_sio_en), 32'(exp_en));
         if (o_sqi_sio_en) begin
            chk("nib_exp_avail", 32'(exp_nib.size() != 0), 1);
            if (exp_nib.size() != 0) chk("sio_nibble", 32'(o_sqi_sio), 32'(exp_nib.pop_front()));
         end
         if (mc < 12) mnib[mc] = o_sqi_sio;
         mc++;
      end
   end

   // Read data is presented on SCK falling so it is stable when the controller samples.
   always @(negedge o_sqi_sck) begin
      if (!o_sqi_cs && {mnib[0], mnib[1]} == 8'h03 && mc >= 8 && mc < 12) begin
         ma_r    = {mnib[2], mnib[3], mnib[4], mnib[5]};
         mb      = (mc < 10) ? mrd(ma_r) : mrd(16'(ma_r + 16'd1));
         mem_sio = mc[0] ? mb[3:0] : mb[7:4];
         mem_drv = 1'b1;
      end else begin
         mem_drv = 1'b0;
         mem_sio = 4'($urandom);
      end
   end

   // ---------------- output monitors ----------------
   int   cs_len = 0;
   logic cs_prev = 1'b1;

   always @(negedge i_clk) begin
      if (mem_drv) chk("sio_conflict", 32'(o_sqi_sio_en), 0);
      if (o_req_rdy) begin
         chk("idle_sck", 32'(o_sqi_sck), 0);
         chk("idle_cs", 32'(o_sqi_cs), 1);
      end
      if (o_rsp_vld) begin
         chk("rsp_after_final", 32'({cs_prev, o_sqi_cs}), 32'(2'b01));
         chk("rsp_exp_avail", 32'(exp_rsp.size() != 0), 1);
         if (exp_rsp.size() != 0) chk("rsp_rdata", 32'(o_rsp_rdata), 32'(exp_rsp.pop_front()));
      end
      if (i_rst) cs_len = 0;
      else if (!o_sqi_cs) cs_len++;
      else if (cs_prev == 1'b0) begin
         chk("cs_exp_avail", 32'(exp_cs.size() != 0), 1);
         if (exp_cs.size() != 0) chk("cs_low_clks", cs_len, exp_cs.pop_front());
         cs_len = 0;
      end
      cs_prev = o_sqi_cs;
   end

   // ---------------- stimulus ----------------
   task automatic push_exp(input logic wr, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] rexp);
      exp_nib.push_back(4'h0);
      exp_nib.push_back(wr ? 4'h2 : 4'h3);
      exp_nib.push_back(a[15:12]);
      exp_nib.push_back(a[11:8]);
      exp_nib.push_back(a[7:4]);
      exp_nib.push_back(a[3:0]);
      if (wr) begin
         exp_nib.push_back(d[7:4]);
         exp_nib.push_back(d[3:0]);
         exp_nib.push_back(d[15:12]);
         exp_nib.push_back(d[11:8]);
         exp_cs.push_back(20);
      end else begin
         exp_cs.push_back(24);
         exp_rsp.push_back(rexp);
      end
   endtask

   task automatic wait_rdy(input string tag);
      int n = 0;
      @(negedge i_clk);
      while (!o_req_rdy && n < 500) begin
         @(negedge i_clk);
         n++;
      end
      chk(tag, 32'(o_req_rdy), 1);
   endtask

   task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] rexp);
      wait_rdy("rdy_before_req");
      push_exp(wr, a, d, rexp);
      i_req_vld   = 1'b1;
      i_req_wr    = wr;
      i_req_addr  = a;
      i_req_wdata = d;
      @(negedge i_clk);
      chk("rdy_drop", 32'(o_req_rdy), 0);
      i_req_vld   = 1'b0;
      i_req_wr    = 1'($urandom);
      i_req_addr  = 16'($urandom);
      i_req_wdata = 16'($urandom);
      wait_rdy("rdy_after_txn");
   endtask

   logic        s_wr   [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [15:0] s_addr [0:3] = '{16'h2000, 16'h2000, 16'h2002, 16'h2002};
   logic [15:0] s_dat  [0:3] = '{16'hC0DE, 16'h0000, 16'h1357, 16'h0000};
   logic [15:0] s_rexp [0:3] = '{16'h0000, 16'hC0DE, 16'h0000, 16'h1357};

   initial begin
      int n;
      i_rst = 1'b1; i_req_vld = 1'b0; i_req_wr = 1'b0;
      i_req_addr = '0; i_req_wdata = '0;
      repeat (3) @(negedge i_clk);
      chk("rst_cs", 32'(o_sqi_cs), 1);
      chk("rst_sck", 32'(o_sqi_sck), 0);
      chk("rst_sio_en", 32'(o_sqi_sio_en), 0);
      chk("rst_rsp_vld", 32'(o_rsp_vld), 0);
      chk("rst_rdy", 32'(o_req_rdy), 0);
      chk("rst_rdata", 32'(o_rsp_rdata), 0);
      chk("rst_sio", 32'(o_sqi_sio), 0);
      @(posedge i_clk); #1 i_rst = 1'b0;
      n = 0;
      while (!o_req_rdy && n < 500) begin
         @(negedge i_clk);
         if (!o_req_rdy) n++;
      end
      chk("rst_gap_clks", n, 2 * GAP);

      do_req(1'b1, 16'h1234, 16'hBEEF, 16'h0000);
      do_req(1'b0, 16'h1234, 16'h0000, 16'hBEEF);
      do_req(1'b1, 16'hFFFF, 16'hA55A, 16'h0000);
      do_req(1'b0, 16'hFFFF, 16'h0000, 16'hA55A);
      chk("wrap_mem_0000", 32'(mrd(16'h0000)), 32'h A5);
      chk("wrap_mem_ffff", 32'(mrd(16'hFFFF)), 32'h5A);
      do_req(1'b1, 16'h0100, 16'h7788, 16'h0000);
      chk("rdata_hold", 32'(o_rsp_rdata), 32'hA55A);

      // Reset in the middle of a write's address phase.
      wait_rdy("rdy_before_abort");
      push_exp(1'b1, 16'h4000, 16'h1111, 16'h0000);
      i_req_vld = 1'b1; i_req_wr = 1'b1; i_req_addr = 16'h4000; i_req_wdata = 16'h1111;
      @(posedge i_clk); #1 i_req_vld = 1'b0;
      repeat (6) @(posedge i_clk);
      #1 chk("abort_cs_low", 32'(o_sqi_cs), 0);
      i_rst = 1'b1;
      #1;
      chk("abort_cs", 32'(o_sqi_cs), 1);
      chk("abort_sck", 32'(o_sqi_sck), 0);
      chk("abort_sio_en", 32'(o_sqi_sio_en), 0);
      chk("abort_rdy", 32'(o_req_rdy), 0);
      chk("abort_rdata", 32'(o_rsp_rdata), 0);
      chk("abort_sio", 32'(o_sqi_sio), 0);
      exp_nib.delete();
      exp_cs.delete();
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      do_req(1'b0, 16'h4000, 16'h0000, {pat(16'h4001), pat(16'h4000)});
      chk("abort_mem", 32'(mrd(16'h4000)), 32'(pat(16'h4000)));

      // Request valid held high across alternating write/read transactions.
      wait_rdy("rdy_before_stream");
      push_exp(s_wr[0], s_addr[0], s_dat[0], s_rexp[0]);
      i_req_vld = 1'b1; i_req_wr = s_wr[0]; i_req_addr = s_addr[0]; i_req_wdata = s_dat[0];
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!o_req_rdy && n < 500) begin
            @(negedge i_clk);
            n++;
         end
         chk("stream_rdy", 32'(o_req_rdy), 1);
         if (k > 0) chk("stream_interval", n, (s_wr[k-1] ? 20 : 24) + 2 * GAP);
         @(posedge i_clk); #1;
         if (k < 3) begin
            push_exp(s_wr[k+1], s_addr[k+1], s_dat[k+1], s_rexp[k+1]);
            i_req_wr = s_wr[k+1]; i_req_addr = s_addr[k+1]; i_req_wdata = s_dat[k+1];
         end else i_req_vld = 1'b0;
         @(negedge i_clk);
      end
      wait_rdy("rdy_after_stream");
      repeat (5) @(negedge i_clk);
      chk("nib_q_empty", exp_nib.size(), 0);
      chk("rsp_q_empty", exp_rsp.size(), 0);
      chk("cs_q_empty", exp_cs.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
